dcache_vldrty_sweeper: RTL and testbench
========================================

# dcache_vldrty_sweeper

Sequencer and port arbiter for the data cache valid/dirty SRAM. After reset, and whenever a full-cache invalidation is requested, it walks every set index and writes valid=0/dirty=0 for all ways, one index per cycle. It also accepts single-line invalidations (index plus way mask). When idle it passes the upstream tag-compare arbiter port through to the SRAM. It sits between the tag-compare/arbitration stage and the valid/dirty `tc_sram`.

## Interface
- `NumWords`, 256: sets per way; power of two, at least 2.
- `NumWays`, 8: associativity.
- `IdxW`, $clog2(NumWords): set index width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `sweep_req_i` in 1: full-invalidate request; held high until `sweep_ack_o`.
- `sweep_ack_o` out 1: single-cycle completion pulse.
- `inv_valid_i` in 1: single-line invalidate request valid.
- `inv_ready_o` out 1: single-line request accepted when valid & ready.
- `inv_index_i` in IdxW: set index to invalidate.
- `inv_way_i` in NumWays: way mask to invalidate.
- `up_req_i` in 1: upstream SRAM request.
- `up_gnt_o` out 1: upstream granted this cycle.
- `up_we_i` in 1: upstream write enable.
- `up_addr_i` in IdxW: upstream index.
- `up_wdata_i` in 8*NumWays: upstream data. For way i, bit 8i = dirty and bit 8i+1 = valid; all other bits are don't-care.
- `up_be_i` in NumWays: upstream per-way byte enable.
- `sram_req_o`, `sram_we_o` out 1: SRAM request and write enable.
- `sram_addr_o` out IdxW: SRAM index.
- `sram_wdata_o` out 8*NumWays: SRAM write data.
- `sram_be_o` out NumWays: SRAM per-way byte enable.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- States:
  - INIT: automatic sweep after reset.
  - IDLE
  - SWEEP: requested sweep.
  - SINGLE: one-cycle single-line write.
- Registers:
  - `cnt_q` (IdxW)
  - `inv_idx_q`, `inv_way_q`
  - state
- INIT and SWEEP:
  - Drive `sram_req_o`=1, `sram_we_o`=1, `sram_addr_o`=`cnt_q`, `sram_wdata_o`=0, `sram_be_o`=all ones.
  - `cnt_q` increments every cycle.
  - When `cnt_q`=NumWords-1, the next state is IDLE and `cnt_q` wraps to 0.
  - In SWEEP only, `sweep_ack_o`=1 in that last-write cycle. INIT never pulses ack.
- IDLE priority: `sweep_req_i` > `inv_valid_i` > `up_req_i`.
  - `sweep_req_i`=1: next state is SWEEP. No SRAM access this cycle; `up_gnt_o`=0 and `inv_ready_o`=0.
  - Else `inv_valid_i`=1: `inv_ready_o`=1. Capture the index and way mask, next state is SINGLE. `up_gnt_o`=0 and SRAM is idle this cycle.
  - Else: pass-through. `sram_*` = `up_*`, `sram_req_o`=`up_req_i`, `up_gnt_o`=`up_req_i`.
- `inv_ready_o` is high only in IDLE with `sweep_req_i`=0.
- SINGLE:
  - Drive `sram_req_o`=1, `sram_we_o`=1, `sram_addr_o`=`inv_idx_q`, `sram_wdata_o`=0, `sram_be_o`=`inv_way_q`.
  - Next state is IDLE.
  - A way mask of 0 still issues the write, with all enables low.
- Outside IDLE: `up_gnt_o`=0 and `inv_ready_o`=0. Upstream must hold its request until granted.
- `sweep_req_i` is sampled only in IDLE. The requester drops it in the ack cycle; if it is still high in the following IDLE cycle, a new sweep starts.
- `sweep_req_i` falling during SWEEP: the sweep still completes and ack still pulses.
- `rst_i` asserted in any state, including mid-sweep: next state INIT, `cnt_q`=0, SINGLE capture discarded.

## Timing
- Values in the first cycle after a reset edge:
  - state INIT, `sram_req_o`=1, `sram_we_o`=1, `sram_addr_o`=0, `sram_wdata_o`=0, `sram_be_o`=all ones
  - `up_gnt_o`=0, `inv_ready_o`=0, `sweep_ack_o`=0, `busy_o`=1
- INIT lasts exactly NumWords cycles. IDLE is first reached NumWords cycles after reset deasserts.
- Requested sweep: request seen in IDLE at cycle t. Writes occur in cycles t+1 … t+NumWords; ack at t+NumWords; IDLE at t+NumWords+1.
- Single invalidate: accepted at t, write at t+1, IDLE at t+2. Back-to-back invalidations are accepted every 2 cycles.
- All `sram_*`, `up_gnt_o`, `inv_ready_o` and `sweep_ack_o` are combinational from the registered state and the inputs. There are no combinational paths from SRAM read data.

## Test plan
- Reset, NumWords=256:
  - Writes to indices 0..255 with be=0xFF and wdata=0 on consecutive cycles.
  - No `sweep_ack_o`.
  - `busy_o` falls at cycle 256.
- Sweep request in IDLE:
  - Writes in cycles t+1..t+256, ack exactly once at t+256.
  - `up_req_i` held high throughout gets no grant until t+257.
- Simultaneous `inv_valid_i` (idx=0x2A, way=0x04) and `up_req_i` in IDLE:
  - Invalidation accepted at t, and at t+1 the SRAM writes idx 0x2A with be=0x04.
  - `up_gnt_o` is first high at t+2.
- Simultaneous `sweep_req_i` and `inv_valid_i`:
  - `inv_ready_o`=0 and the sweep runs.
  - The invalidation is accepted in the first IDLE cycle after ack, once `sweep_req_i` has dropped.
- Pass-through write (addr 0x10, be=0x81, wdata bit 1 set):
  - SRAM outputs equal the inputs in the same cycle, `up_gnt_o`=1.
- `rst_i` at sweep index 100:
  - Next cycle is INIT at index 0, followed by a full 256-cycle sweep.
  - No ack for the aborted sweep.

Source files
------------

// File: rtl/dcache_vldrty_sweeper.sv
// Valid/dirty SRAM port sequencer: full-cache invalidation sweeps (after reset and on request),
// single-line invalidations, and pass-through of the upstream tag-compare port when idle.
module dcache_vldrty_sweeper #(
    parameter int unsigned NumWords = 256,
    parameter int unsigned NumWays  = 8,
    parameter int unsigned IdxW     = $clog2(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sweep_req_i,
    output logic                   sweep_ack_o,
    input  logic                   inv_valid_i,
    output logic                   inv_ready_o,
    input  logic [IdxW-1:0]        inv_index_i,
    input  logic [NumWays-1:0]     inv_way_i,
    input  logic                   up_req_i,
    output logic                   up_gnt_o,
    input  logic                   up_we_i,
    input  logic [IdxW-1:0]        up_addr_i,
    input  logic [8*NumWays-1:0]   up_wdata_i,
    input  logic [NumWays-1:0]     up_be_i,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [IdxW-1:0]        sram_addr_o,
    output logic [8*NumWays-1:0]   sram_wdata_o,
    output logic [NumWays-1:0]     sram_be_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {INIT, IDLE, SWEEP, SINGLE} state_e;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     inv_idx_q, inv_idx_d;
    logic [NumWays-1:0]  inv_way_q, inv_way_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            inv_idx_q <= '0;
            inv_way_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inv_idx_q <= inv_idx_d;
            inv_way_q <= inv_way_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inv_idx_d    = inv_idx_q;
        inv_way_d    = inv_way_q;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        up_gnt_o     = 1'b0;
        inv_ready_o  = 1'b0;
        sweep_ack_o  = 1'b0;
        unique case (state_q)
            INIT, SWEEP: begin
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = cnt_q;
                sram_be_o   = '1;
                cnt_d       = cnt_q + IdxW'(1);
                if (cnt_q == LastIdx) begin
                    // Only a requested sweep is acknowledged; the reset sweep is silent.
                    state_d     = IDLE;
                    cnt_d       = '0;
                    sweep_ack_o = (state_q == SWEEP);
                end
            end
            IDLE: begin
                if (sweep_req_i) begin
                    state_d = SWEEP;
                end else if (inv_valid_i) begin
                    inv_ready_o = 1'b1;
                    inv_idx_d   = inv_index_i;
                    inv_way_d   = inv_way_i;
                    state_d     = SINGLE;
                end else begin
                    sram_req_o   = up_req_i;
                    sram_we_o    = up_we_i;
                    sram_addr_o  = up_addr_i;
                    sram_wdata_o = up_wdata_i;
                    sram_be_o    = up_be_i;
                    up_gnt_o     = up_req_i;
                end
            end
            SINGLE: begin
                // A zero way mask still issues the write, just with no enables.
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = inv_idx_q;
                sram_be_o   = inv_way_q;
                state_d     = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_vldrty_sweeper.sv
// Randomized bench for dcache_vldrty_sweeper; the reference keeps a queue of SRAM writes
// the block still owes, and predicts pass-through/accept behaviour whenever that queue is empty.
module tb_dcache_vldrty_sweeper;

    localparam int NW   = 256;
    localparam int WAYS = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] be;
        logic       ack;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        sweep_req, sweep_ack;
    logic        inv_valid, inv_ready;
    logic [7:0]  inv_index;
    logic [7:0]  inv_way;
    logic        up_req, up_gnt, up_we;
    logic [7:0]  up_addr;
    logic [63:0] up_wdata;
    logic [7:0]  up_be;
    logic        sram_req, sram_we;
    logic [7:0]  sram_addr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_be;
    logic        busy;

    int  n_chk  = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    bit  last_ack;
    bit  inv_acc;
    bit  sweep_hold;

    dcache_vldrty_sweeper #(.NumWords(NW), .NumWays(WAYS)) dut (
        .clk_i(clk), .rst_i(rst),
        .sweep_req_i(sweep_req), .sweep_ack_o(sweep_ack),
        .inv_valid_i(inv_valid), .inv_ready_o(inv_ready),
        .inv_index_i(inv_index), .inv_way_i(inv_way),
        .up_req_i(up_req), .up_gnt_o(up_gnt), .up_we_i(up_we),
        .up_addr_i(up_addr), .up_wdata_i(up_wdata), .up_be_i(up_be),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A full sweep owes one all-ways write per index; only the last of a requested one acks.
    task automatic push_sweep(input bit acked);
        wr_t w;
        for (int i = 0; i < NW; i++) begin
            w.addr = 8'(i);
            w.be   = 8'hFF;
            w.ack  = acked && (i == NW - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; sweep_req = 1'b0; inv_valid = 1'b0; inv_index = '0; inv_way = '0;
        up_req = 1'b0; up_we = 1'b0; up_addr = '0; up_wdata = '0; up_be = '0;
    endtask

    // Inputs are already driven (1 time unit after the edge); check, advance model, next cycle.
    task automatic step();
        logic e_busy, e_req, e_we, e_gnt, e_rdy, e_ack;
        logic [7:0]  e_addr, e_be;
        logic [63:0] e_wd;
        bit          chk_data;
        wr_t         w;
        #2;
        e_busy = 0; e_req = 0; e_we = 0; e_gnt = 0; e_rdy = 0; e_ack = 0;
        e_addr = '0; e_be = '0; e_wd = '0; chk_data = 1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            e_busy = 1; e_req = 1; e_we = 1; e_addr = w.addr; e_be = w.be; e_ack = w.ack;
        end else if (sweep_req) begin
            chk_data = 0;
            push_sweep(1'b1);
        end else if (inv_valid) begin
            chk_data = 0;
            e_rdy = 1;
            w.addr = inv_index; w.be = inv_way; w.ack = 1'b0;
            exp_q.push_back(w);
            inv_acc = 1;
        end else begin
            e_req = up_req; e_gnt = up_req; e_we = up_we;
            e_addr = up_addr; e_wd = up_wdata; e_be = up_be;
        end
        chk("busy", busy, e_busy);
        chk("sram_req", sram_req, e_req);
        chk("up_gnt", up_gnt, e_gnt);
        chk("inv_ready", inv_ready, e_rdy);
        chk("sweep_ack", sweep_ack, e_ack);
        if (chk_data) begin
            chk("sram_we", sram_we, e_we);
            chk("sram_addr", sram_addr, e_addr);
            chk("sram_wdata", sram_wdata, e_wd);
            chk("sram_be", sram_be, e_be);
        end
        last_ack = e_ack;
        if (rst) begin
            exp_q.delete();
            push_sweep(1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        sweep_hold = 0;
        inv_acc = 0;
        @(posedge clk);
        #1;
        push_sweep(1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < NW + 4; i++) step();

        // Pass-through write
        up_req = 1; up_we = 1; up_addr = 8'h10; up_be = 8'h81; up_wdata = 64'h2;
        step();
        idle_inputs();

        // Requested sweep with upstream held throughout
        sweep_hold = 1;
        up_req = 1; up_addr = 8'h33; up_be = 8'h0F; up_wdata = 64'h0202;
        for (int i = 0; i < NW + 3; i++) begin
            sweep_req = sweep_hold;
            step();
            if (last_ack) sweep_hold = 0;
        end
        idle_inputs();

        // Invalidate and upstream together
        inv_valid = 1; inv_index = 8'h2A; inv_way = 8'h04; up_req = 1; up_addr = 8'h55; up_be = 8'hFF;
        step();
        inv_valid = 0;
        for (int i = 0; i < 3; i++) step();
        idle_inputs();

        // Sweep and invalidate together: invalidate waits until after the ack
        sweep_hold = 1;
        inv_acc = 0;
        inv_valid = 1; inv_index = 8'h91; inv_way = 8'h00;
        for (int i = 0; i < NW + 10 && !inv_acc; i++) begin
            sweep_req = sweep_hold;
            step();
            if (last_ack) sweep_hold = 0;
        end
        chk("inv_after_sweep", inv_acc, 1'b1);
        idle_inputs();
        for (int i = 0; i < 3; i++) step();

        // Reset in the middle of a sweep, at index 100
        sweep_req = 1;
        step();
        sweep_req = 0;
        for (int i = 0; i < 100; i++) step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < NW + 4; i++) step();

        // Random traffic
        sweep_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            if (!sweep_hold && $urandom_range(0, 59) == 0) sweep_hold = 1;
            else if (sweep_hold && exp_q.size() > 0 && $urandom_range(0, 199) == 0) sweep_hold = 0;
            sweep_req = sweep_hold;
            inv_valid = ($urandom_range(0, 3) == 0);
            inv_index = 8'($urandom);
            inv_way   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            up_req    = $urandom_range(0, 1);
            up_we     = $urandom_range(0, 1);
            up_addr   = 8'($urandom);
            up_wdata  = {$urandom, $urandom};
            up_be     = 8'($urandom);
            step();
            if (last_ack || rst) sweep_hold = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
